// File: rtl/fetch_queue.sv
// Instruction prefetch queue: issues sequential fetches to a one-cycle-latency
// instruction memory and buffers returned {pc, instr} pairs for decode.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     id_valid,
    output logic [31:0]              id_instr,
    output logic [31:0]              id_pc,
    input  logic                     id_stall,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];

    logic [CW:0]   credit_used;
    logic          enq;
    logic          deq;
    logic          queue_nonempty;

    assign queue_nonempty = (count != '0);
    assign credit_used    = {1'b0, count} + {{CW{1'b0}}, inflight};

    // Credit ignores a same-cycle dequeue; gating with rst_n keeps the
    // request low for the whole reset window.
    assign imem_req  = rst_n && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign imem_addr = fetch_pc;

    assign enq = inflight && !redirect;
    assign deq = queue_nonempty && !id_stall && !redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~32'h0000_0003;
            inflight <= 1'b0;
        end else if (imem_req) begin
            fetch_pc    <= fetch_pc + 32'd4;
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible while count covers them.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr]    <= inflight_pc;
            instr_mem[wr_ptr] <= imem_rdata;
        end
    end

    assign id_valid = queue_nonempty;
    assign id_instr = queue_nonempty ? instr_mem[rd_ptr] : NOP_INSTR;
    assign id_pc    = queue_nonempty ? pc_mem[rd_ptr] : 32'h0000_0000;
    assign fq_count = count;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: hand-derived per-cycle vector table, scoreboard
// monitor with its own occupancy model, wrap-around and async-reset sequences.
`timescale 1ns/1ps
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst_w;
    logic        imem_req, imem_req_w;
    logic [31:0] imem_addr, imem_addr_w;
    logic [31:0] imem_rdata, imem_rdata_w;
    logic        id_valid, id_valid_w;
    logic [31:0] id_instr, id_instr_w, id_pc, id_pc_w;
    logic        id_stall, redirect;
    logic [31:0] redirect_pc;
    logic [2:0]  fq_count, fq_count_w;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_stall(id_stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .fq_count(fq_count)
    );

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_rdata(imem_rdata_w), .id_valid(id_valid_w), .id_instr(id_instr_w),
        .id_pc(id_pc_w), .id_stall(1'b0), .redirect(1'b0),
        .redirect_pc(32'h0000_0000), .fq_count(fq_count_w)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // One-cycle-latency memory; garbage when no request was made.
    always @(posedge clk) begin
        imem_rdata   <= imem_req   ? word_of(imem_addr)   : 32'hDEAD_BEEF;
        imem_rdata_w <= imem_req_w ? word_of(imem_addr_w) : 32'hDEAD_BEEF;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: one entry per issued request, visible two cycles later.
    typedef struct {
        logic [31:0] pc;
        int          ready;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] exp_fpc;
    int          cyc    = 0;
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        logic        e_req, e_valid;
        int          e_cnt;
        logic [31:0] e_pc;
        if (mon_en) begin
            if (!rst_n) begin
                sb.delete();
                exp_fpc = 32'h0000_0000;
            end
            e_cnt = 0;
            foreach (sb[i]) if (sb[i].ready <= cyc) e_cnt++;
            e_valid = (e_cnt > 0);
            e_req   = rst_n && !redirect && (sb.size() < DEPTH);
            e_pc    = e_valid ? sb[0].pc : 32'h0;
            check32("mon_req",   {31'b0, imem_req}, {31'b0, e_req});
            check32("mon_addr",  imem_addr, exp_fpc);
            check32("mon_valid", {31'b0, id_valid}, {31'b0, e_valid});
            check32("mon_count", {29'b0, fq_count}, e_cnt);
            check32("mon_pc",    id_pc, e_pc);
            check32("mon_instr", id_instr, e_valid ? word_of(e_pc) : NOP);
            if (rst_n) begin
                if (redirect) begin
                    sb.delete();
                    exp_fpc = redirect_pc & ~32'h3;
                end else begin
                    if (e_valid && !id_stall) void'(sb.pop_front());
                    if (e_req) begin
                        sb.push_back('{pc: exp_fpc, ready: cyc + 2});
                        exp_fpc = exp_fpc + 32'd4;
                    end
                end
            end
            cyc++;
        end
    end

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        int          e_cnt;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input logic s, input logic r, input logic [31:0] rp,
                                input logic q, input logic [31:0] a,
                                input logic v, input logic [31:0] p, input int c);
        vec_t t;
        t.stall = s; t.redir = r; t.rpc = rp; t.e_req = q; t.e_addr = a;
        t.e_valid = v; t.e_pc = p; t.e_cnt = c;
        return t;
    endfunction

    logic [31:0] wrap_addr [4];

    initial begin
        // cycle index = cycles since reset release
        tab.push_back(mk(0, 0, 0,        1, 32'h000, 0, 0,       0)); // 0
        tab.push_back(mk(0, 0, 0,        1, 32'h004, 0, 0,       0));
        tab.push_back(mk(0, 0, 0,        1, 32'h008, 1, 32'h000, 1));
        tab.push_back(mk(0, 0, 0,        1, 32'h00C, 1, 32'h004, 1));
        tab.push_back(mk(0, 0, 0,        1, 32'h010, 1, 32'h008, 1));
        tab.push_back(mk(1, 0, 0,        1, 32'h014, 1, 32'h00C, 1)); // 5 stall
        tab.push_back(mk(1, 0, 0,        1, 32'h018, 1, 32'h00C, 2));
        tab.push_back(mk(1, 0, 0,        0, 32'h0,   1, 32'h00C, 3));
        tab.push_back(mk(1, 0, 0,        0, 32'h0,   1, 32'h00C, 4));
        tab.push_back(mk(1, 0, 0,        0, 32'h0,   1, 32'h00C, 4));
        tab.push_back(mk(0, 0, 0,        0, 32'h0,   1, 32'h00C, 4)); // 10 release
        tab.push_back(mk(0, 0, 0,        1, 32'h01C, 1, 32'h010, 3));
        tab.push_back(mk(0, 0, 0,        1, 32'h020, 1, 32'h014, 2));
        tab.push_back(mk(0, 0, 0,        1, 32'h024, 1, 32'h018, 2));
        tab.push_back(mk(0, 1, 32'h103,  0, 32'h0,   1, 32'h01C, 2)); // 14 redirect
        tab.push_back(mk(0, 0, 0,        1, 32'h100, 0, 0,       0));
        tab.push_back(mk(0, 0, 0,        1, 32'h104, 0, 0,       0));
        tab.push_back(mk(0, 0, 0,        1, 32'h108, 1, 32'h100, 1));
        tab.push_back(mk(0, 0, 0,        1, 32'h10C, 1, 32'h104, 1));
        tab.push_back(mk(1, 0, 0,        1, 32'h110, 1, 32'h108, 1)); // 19 stall
        tab.push_back(mk(1, 0, 0,        1, 32'h114, 1, 32'h108, 2));
        tab.push_back(mk(1, 0, 0,        0, 32'h0,   1, 32'h108, 3));
        tab.push_back(mk(1, 0, 0,        0, 32'h0,   1, 32'h108, 4));
        tab.push_back(mk(1, 1, 32'h200,  0, 32'h0,   1, 32'h108, 4)); // 23 redirect when full
        tab.push_back(mk(1, 0, 0,        1, 32'h200, 0, 0,       0));
        tab.push_back(mk(0, 0, 0,        1, 32'h204, 0, 0,       0));
        tab.push_back(mk(0, 0, 0,        1, 32'h208, 1, 32'h200, 1));
        tab.push_back(mk(1, 0, 0,        1, 32'h20C, 1, 32'h204, 1));
        tab.push_back(mk(1, 0, 0,        1, 32'h210, 1, 32'h204, 2));

        wrap_addr[0] = 32'hFFFF_FFF8;
        wrap_addr[1] = 32'hFFFF_FFFC;
        wrap_addr[2] = 32'h0000_0000;
        wrap_addr[3] = 32'h0000_0004;

        rst_n = 1'b1; rst_w = 1'b1;
        id_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #1 rst_n = 1'b0; rst_w = 1'b0;
        #1 mon_en = 1'b1;

        // Wrap-around instance
        repeat (2) @(posedge clk);
        #1 rst_w = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #2;
            if (i < 4) begin
                check32("wrap_req",  {31'b0, imem_req_w}, 32'd1);
                check32("wrap_addr", imem_addr_w, wrap_addr[i]);
            end
            if (i >= 2) begin
                check32("wrap_valid", {31'b0, id_valid_w}, 32'd1);
                check32("wrap_pc",    id_pc_w, wrap_addr[i-2]);
                check32("wrap_instr", id_instr_w, word_of(wrap_addr[i-2]));
            end
            @(posedge clk);
            #1;
        end

        // Table-driven vectors, one row per cycle after reset release
        for (int i = 0; i < tab.size(); i++) begin
            rst_n       = 1'b1;
            id_stall    = tab[i].stall;
            redirect    = tab[i].redir;
            redirect_pc = tab[i].rpc;
            #2;
            check32($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, tab[i].e_req});
            if (tab[i].e_req)
                check32($sformatf("vec%0d_addr", i), imem_addr, tab[i].e_addr);
            check32($sformatf("vec%0d_valid", i), {31'b0, id_valid}, {31'b0, tab[i].e_valid});
            check32($sformatf("vec%0d_count", i), {29'b0, fq_count}, tab[i].e_cnt);
            check32($sformatf("vec%0d_pc", i), id_pc, tab[i].e_valid ? tab[i].e_pc : 32'h0);
            check32($sformatf("vec%0d_instr", i), id_instr,
                    tab[i].e_valid ? word_of(tab[i].e_pc) : NOP);
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-cycle with three entries queued
        id_stall = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        #1;
        check32("pre_rst_count", {29'b0, fq_count}, 32'd3);
        rst_n = 1'b0;
        #1;
        check32("arst_valid", {31'b0, id_valid}, 32'd0);
        check32("arst_count", {29'b0, fq_count}, 32'd0);
        check32("arst_req",   {31'b0, imem_req}, 32'd0);
        check32("arst_instr", id_instr, NOP);
        check32("arst_addr",  imem_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; id_stall = 1'b0;
        #2;
        check32("rel_req",  {31'b0, imem_req}, 32'd1);
        check32("rel_addr", imem_addr, 32'h0);
        check32("rel_valid", {31'b0, id_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #3;
        check32("rel_first_valid", {31'b0, id_valid}, 32'd1);
        check32("rel_first_pc",    id_pc, 32'h0);

        // Random stall / redirect traffic checked by the monitor
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            id_stall    = ($urandom_range(0, 2) == 0);
            redirect    = ($urandom_range(0, 24) == 0);
            redirect_pc = $urandom;
        end
        @(posedge clk);
        #1 id_stall = 1'b0; redirect = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch stage between the instruction memory and the decode pipeline register. It generates sequential fetch addresses and issues requests to a synchronous instruction memory with one-cycle read latency. Returned words and their PCs are buffered in a small FIFO, which presents one instruction per cycle to decode. It absorbs decode stalls without losing fetched words and flushes cleanly on a control-flow redirect.

## Interface
Parameters:
- DEPTH, 4 — queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000 — first fetch address after reset.

Ports:
- clk  in  1  — single clock; all state updates on the rising edge.
- rst_n  in  1  — asynchronous, active-low reset.
- imem_req  out  1  — fetch request this cycle.
- imem_addr  out  32  — byte address of the request; always equals fetch_pc.
- imem_rdata  in  32  — instruction word; valid the cycle after the matching imem_req.
- id_valid  out  1  — head entry is valid.
- id_instr  out  32  — head instruction; 32'h0000_0013 (NOP) when id_valid=0.
- id_pc  out  32  — head PC; 0 when id_valid=0.
- id_stall  in  1  — decode cannot accept the head this cycle.
- redirect  in  1  — flush the queue and restart fetch.
- redirect_pc  in  32  — new fetch address; bits [1:0] ignored and forced to 0.
- fq_count  out  $clog2(DEPTH)+1  — current occupancy.

## Operation
- State:
  - fetch_pc
  - DEPTH-entry FIFO of {pc, instr} with rd_ptr, wr_ptr and count
  - inflight flag with inflight_pc
- Request rule: imem_req = !redirect && (count + inflight < DEPTH).
  - Credit does not consider a same-cycle dequeue, so this rule is conservative.
  - On a request: fetch_pc ← fetch_pc + 4 (wraps modulo 2^32), inflight ← 1, inflight_pc ← fetch_pc.
  - Without a request: inflight ← 0.
- Enqueue: when inflight=1 and no redirect, write {inflight_pc, imem_rdata} at wr_ptr; wr_ptr wraps modulo DEPTH.
- Dequeue: when count>0, !id_stall and !redirect, advance rd_ptr (wraps modulo DEPTH).
- Count update:
  - Enqueue and dequeue in the same cycle: count unchanged, including when count=DEPTH−1 or count=1.
  - The credit rule guarantees count never exceeds DEPTH and no write occurs while full.
- Output: head is the entry at rd_ptr; id_valid = (count>0). There is no bypass, so a response becomes visible the cycle after it returns.
- Redirect (highest priority, beats stall, enqueue and dequeue). In the redirect cycle:
  - count, rd_ptr and wr_ptr are cleared to 0.
  - An in-flight response is discarded and inflight ← 0.
  - fetch_pc ← {redirect_pc[31:2], 2'b00}.
  - imem_req = 0.
- Stall with count=0: no effect beyond holding outputs.

## Timing
- Reset values while rst_n=0 and immediately after release:
  - fetch_pc = RESET_PC, imem_addr = RESET_PC
  - imem_req = 0 while rst_n=0
  - id_valid = 0, id_instr = 32'h13, id_pc = 0
  - fq_count = 0, inflight = 0
- First cycle after reset release: imem_req=1 at RESET_PC.
- Latency:
  - Cycle N: request issued.
  - Cycle N+1: word returns and is enqueued.
  - Cycle N+2: id_valid=1 with that word.
- Steady state, no stall: one request and one dequeue per cycle; count settles at 1.
- Stall held: at most DEPTH words are buffered, then imem_req drops.
  - After stall release, the first request issues in the cycle after count drops below DEPTH.
  - The queue is never overrun.
- Redirect at cycle R:
  - Cycle R+1: imem_req=1, imem_addr=redirect_pc.
  - Cycle R+3: first new id_valid=1.
  - No stale instruction is ever presented after R.
- Redirect while id_stall=1: the flush still happens; the stalled head is dropped.
- Asynchronous reset mid-operation: all state returns to reset values immediately, and any in-flight response is dropped.

## Test plan
- Reset release, id_stall=0, with memory returning word = address: imem_addr sequence 0,4,8,…; id_valid rises 2 cycles after the first request; id_pc/id_instr pairs match 0/0, 4/4, 8/8, …
- Hold id_stall=1 for 10 cycles from steady state: fq_count reaches 4 and imem_req=0. On release, output continues with no gap or duplicate PC until the queue drains, then resumes one instruction per cycle.
- Pulse redirect with redirect_pc=0x103 while a request is in flight: the next request is at 0x100; no PC from the old stream appears after the redirect cycle; first id_pc=0x100 three cycles later.
- Pulse redirect while id_stall=1 and the queue is full: fq_count=0 next cycle; id_valid=0 for 2 cycles; then id_pc=redirect target.
- Set RESET_PC=0xFFFF_FFF8 and free-run: request addresses are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Assert rst_n=0 asynchronously, mid-cycle, with the queue 3 deep: id_valid=0, fq_count=0 and imem_req=0 immediately. After release, fetch restarts at RESET_PC.
